regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the core's decode/writeback boundary. It supports configurable width and depth and an arbitrary number of read and write ports. An optional hardwired zero register is available, along with same-cycle write-to-read bypass and deterministic write-port priority. After reset, or on request, a sequential clear engine zeroes the array one entry per cycle and reports readiness, so the array needs no single-cycle global reset fan-out.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers; power of two, at least 2
- NUM_RD, 2, number of read ports, at least 1
- NUM_WR, 1, number of write ports, at least 1
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a same-cycle write to an address being read is forwarded to that read port
- Derived: AW = $clog2(DEPTH)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- clear_i  in  1  pulse that restarts the clear sequence
- ready_o  out  1  high when the array is initialised and accepting writes
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR*AW  write addresses; port k occupies bits [k*AW +: AW]
- wr_data_i  in  NUM_WR*WIDTH  write data; port k occupies bits [k*WIDTH +: WIDTH]
- rd_addr_i  in  NUM_RD*AW  read addresses, packed the same way
- rd_data_o  out  NUM_RD*WIDTH  read data, combinational from rd_addr_i

## Operation
- FSM states are CLEAR and RUN, with a clear counter clr_cnt of AW bits.
- rst_i high at an edge: state <= CLEAR and clr_cnt <= 0. Array contents are not touched at this edge.
- CLEAR state, rst_i low, at each edge: mem[clr_cnt] <= 0 and clr_cnt increments. If clr_cnt == DEPTH-1, state <= RUN.
- RUN state, clear_i high at an edge: state <= CLEAR and clr_cnt <= 0. All writes in that cycle are dropped.
- clear_i is ignored in CLEAR; the sequence does not restart.
- ready_o = (state == RUN). It is combinational from the state register only.
- In CLEAR, wr_en_i is ignored and every rd_data_o lane reads 0.
- In RUN, for each write port k with wr_en_i[k]: mem[wr_addr_k] <= wr_data_k at the edge.
  - If ZERO_REG=1 and the address is 0, the write is discarded.
- Write conflict: when several enabled ports target the same address, the highest-index port wins. Other ports writing different addresses in the same cycle complete normally.
- Read port j in RUN: if ZERO_REG=1 and rd_addr_j == 0, the port returns 0.
  - Otherwise, if BYPASS=1 and any enabled write port targets rd_addr_j, the port returns that port's wr_data. The highest-index matching port is used.
  - Otherwise the port returns mem[rd_addr_j].
- No port range errors are possible, because DEPTH is a power of two.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge; with BYPASS=0, new data becomes visible on the cycle after the write.
- The clear sequence takes exactly DEPTH edges. With rst_i deasserted before edge 1, ready_o rises after edge DEPTH.
- Reset values: ready_o=0 and rd_data_o=0 on all lanes, from the first edge with rst_i high until the clear sequence completes.
- Reset asserted mid-clear: clr_cnt returns to 0 and the full DEPTH-cycle sequence restarts after deassertion.
- clear_i and rst_i high together: reset behaviour applies.
- Write enabled on the edge where the state goes CLEAR->RUN: the write is dropped, because the state was still CLEAR. The first accepted write is on the first edge with ready_o=1.

## Test plan
- Reset/clear timing (DEPTH=32): hold rst_i for 3 cycles, release, and drive writes throughout. Required: ready_o stays 0 for exactly 32 edges and then rises; every read returns 0; no drive-time write is retained.
- Basic write/read: write 0xDEADBEEF to reg 5 via port 0, then read reg 5 on ports 0 and 1 the next cycle. Required: both ports return 0xDEADBEEF. Also write 0x1234 to reg 0. Required: reads of reg 0 return 0 (ZERO_REG=1).
- Bypass (BYPASS=1): in one cycle, write 0xA5A5A5A5 to reg 7 and read reg 7. Required: the same cycle shows 0xA5A5A5A5. Repeat with BYPASS=0. Required: the old value is shown that cycle and 0xA5A5A5A5 the next.
- Write conflict (NUM_WR=2): port 0 writes 0x11 and port 1 writes 0x22 to reg 9 in one cycle, while port 0 also targets reg 3 in a separate check. Required: reg 9 reads 0x22, the bypass read of reg 9 shows 0x22, and a non-conflicting write lands intact.
- clear_i in RUN: fill regs 1..31 with nonzero data, then pulse clear_i together with a write of 0x55 to reg 2. Required: ready_o drops the next cycle, reg 2 is not written, and after 32 edges all registers read 0.
- Reset mid-clear: assert rst_i when clr_cnt == 10. Required: after release, ready_o rises exactly 32 edges later.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a sequential clear engine, optional zero register and write-to-read bypass.
// Latency: reads are combinational (0 cycles); writes land on the next rising edge.
// Backpressure: ready_o low during the DEPTH-cycle clear; writes are dropped and reads return 0 while low.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    output logic                    ready_o,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*AW-1:0]    wr_addr_i,
    input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
    input  logic [NUM_RD*AW-1:0]    rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o
);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic [AW-1:0]     rd_a;
    logic [WIDTH-1:0]  rd_v;

    // Next-state: walk the clear counter through every entry, then run until clear_i is seen.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear_i) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State register; reset only restarts the clear sequence, it never touches the array.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array update: one entry zeroed per cycle while clearing, otherwise port writes in ascending
    // order so the highest-index port wins an address conflict.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (!clear_i) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en_i[k] &&
                        !((ZERO_REG != 0) && (wr_addr_i[k*AW +: AW] == '0))) begin
                        mem_q[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    assign ready_o = (state_q == RUN);

    // Read lanes: zero while clearing, zero-register override, then bypass from the highest matching port.
    always_comb begin
        rd_data_o = '0;
        rd_a      = '0;
        rd_v      = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_a = rd_addr_i[j*AW +: AW];
            rd_v = '0;
            if (state_q == RUN && !((ZERO_REG != 0) && (rd_a == '0))) begin
                rd_v = mem_q[rd_a];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == rd_a)) begin
                            rd_v = wr_data_i[k*WIDTH +: WIDTH];
                        end
                    end
                end
            end
            rd_data_o[j*WIDTH +: WIDTH] = rd_v;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;

    logic              clk = 1'b0;
    logic              rst, clr;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*W-1:0]   wr_data;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_b, rd_n;
    logic              rdy_b, rdy_n;

    int errors = 0;
    int checks = 0;

    // Reference model: array contents, ready flag and how many entries the clear has covered.
    logic [W-1:0] m_mem [DEPTH];
    bit           m_ready = 0;
    int           m_idx   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .ready_o(rdy_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_b));

    regfile_mp #(.WIDTH(W), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .ready_o(rdy_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_n));

    function automatic logic [W-1:0] exp_rd(input int a, input bit byp);
        logic [W-1:0] v;
        if (!m_ready || a == 0) return '0;
        v = m_mem[a];
        if (byp) begin
            for (int k = NW - 1; k >= 0; k--) begin
                if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) return wr_data[k*W +: W];
            end
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("ready_byp", W'(rdy_b), W'(m_ready));
        chk("ready_nobyp", W'(rdy_n), W'(m_ready));
        for (int j = 0; j < NR; j++) begin
            chk("rd_byp", rd_b[j*W +: W], exp_rd(int'(rd_addr[j*AW +: AW]), 1'b1));
            chk("rd_nobyp", rd_n[j*W +: W], exp_rd(int'(rd_addr[j*AW +: AW]), 1'b0));
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_ready = 0;
            m_idx   = 0;
        end else if (!m_ready) begin
            m_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == DEPTH) m_ready = 1;
        end else if (clr) begin
            m_ready = 0;
            m_idx   = 0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wr_en[k] && wr_addr[k*AW +: AW] != '0) m_mem[wr_addr[k*AW +: AW]] = wr_data[k*W +: W];
            end
        end
    endtask

    // One cycle: check settled outputs, take the edge, update the model, step just past the edge.
    task automatic cyc(input bit do_chk = 1'b1);
        #1;
        if (do_chk) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_io(input bit rand_en);
        wr_en   = rand_en ? NW'($urandom_range(0, 3)) : '0;
        wr_addr = NW*AW'($urandom);
        wr_data = {$urandom, $urandom};
        rd_addr = NR*AW'($urandom);
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = AW'(a);
        wr_data[p*W +: W]    = d;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!rdy_b && n < 100) begin
            rand_io(1'b1);
            cyc();
            n++;
        end
        chk(tag, W'(n), W'(DEPTH));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        rand_io(1'b1);
        cyc(1'b0);
        // Reset held with writes driven throughout.
        for (int i = 0; i < 2; i++) begin
            rand_io(1'b1);
            cyc();
        end
        rst = 1'b0;
        wait_ready("reset_clear_edges");
        // Nothing written during the clear survives.
        wr_en = '0;
        for (int a = 0; a < DEPTH; a += 2) begin
            rd(a, a + 1);
            #1;
            chk("post_clear_zero0", rd_b[0 +: W], '0);
            chk("post_clear_zero1", rd_b[W +: W], '0);
            cyc();
        end

        // Basic write/read on port 0 and the zero register.
        wr_en = '0; wr(0, 5, 32'hDEADBEEF); rd(1, 2);
        cyc();
        wr_en = '0; rd(5, 5);
        #1;
        chk("basic_rd0", rd_b[0 +: W], 32'hDEADBEEF);
        chk("basic_rd1", rd_b[W +: W], 32'hDEADBEEF);
        cyc();
        wr(0, 0, 32'h1234); rd(0, 0);
        cyc();
        wr_en = '0;
        #1;
        chk("zero_reg", rd_b[0 +: W], '0);
        cyc();

        // Bypass versus no bypass on reg 7.
        wr(0, 7, 32'h00000077); rd(1, 1);
        cyc();
        wr_en = '0; wr(1, 7, 32'hA5A5A5A5); rd(7, 5);
        #1;
        chk("bypass_same_cycle", rd_b[0 +: W], 32'hA5A5A5A5);
        chk("nobypass_old", rd_n[0 +: W], 32'h00000077);
        cyc();
        wr_en = '0;
        #1;
        chk("nobypass_next", rd_n[0 +: W], 32'hA5A5A5A5);
        cyc();

        // Write conflict on reg 9, then a non-conflicting pair.
        wr(0, 9, 32'h11); wr(1, 9, 32'h22); rd(9, 9);
        #1;
        chk("conflict_bypass", rd_b[0 +: W], 32'h22);
        cyc();
        wr_en = '0; wr(0, 3, 32'h33); wr(1, 4, 32'h44); rd(9, 9);
        #1;
        chk("conflict_stored", rd_n[W +: W], 32'h22);
        cyc();
        wr_en = '0; rd(3, 4);
        #1;
        chk("nonconf_p0", rd_n[0 +: W], 32'h33);
        chk("nonconf_p1", rd_n[W +: W], 32'h44);
        cyc();

        // Random traffic in RUN.
        for (int i = 0; i < 300; i++) begin
            rand_io(1'b1);
            cyc();
        end

        // Fill 1..31, then clear_i with a write to reg 2.
        for (int a = 1; a < DEPTH; a += 2) begin
            wr_en = '0; wr(0, a, 32'h01010101 * a); wr(1, (a + 1) % DEPTH, 32'hF0000000 | a);
            rd(a, a - 1);
            cyc();
        end
        wr_en = '0; wr(0, 2, 32'h55); rd(2, 1); clr = 1'b1;
        cyc();
        clr = 1'b0; wr_en = '0;
        #1;
        chk("clear_drops_ready", W'(rdy_b), '0);
        // clear_i pulses during CLEAR are ignored.
        begin
            int n = 0;
            while (!rdy_b && n < 100) begin
                rand_io(1'b1);
                clr = (n % 7 == 3);
                cyc();
                n++;
            end
            chk("clear_edges", W'(n), W'(DEPTH));
        end
        clr = 1'b0; wr_en = '0;
        for (int a = 0; a < DEPTH; a += 2) begin
            rd(a, a + 1);
            #1;
            chk("after_clear0", rd_n[0 +: W], '0);
            chk("after_clear1", rd_n[W +: W], '0);
            cyc();
        end

        // Reset mid-clear at clr_cnt == 10, with clear_i high alongside reset.
        wr_en = '0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_io(1'b1);
            cyc();
        end
        rst = 1'b1; clr = 1'b1;
        cyc();
        rst = 1'b0; clr = 1'b0;
        wait_ready("reset_midclear_edges");
        for (int i = 0; i < 50; i++) begin
            rand_io(1'b1);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
